// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the fetch PC, drives a single-outstanding
// instruction-memory handshake and feeds instructions/control into IF/ID.
module fetch_sequencer #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCSrcE,
    input  logic [XLEN-1:0]  PCTargetE,
    input  logic             HazStallD,
    input  logic             HazFlushD,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      InstrF,
    output logic [XLEN-1:0]  PCF,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic [CNT_W-1:0] wait_cycles
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [31:0]       buf_instr_q, buf_instr_d;
    logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
    logic [CNT_W-1:0]  wait_q, wait_d;

    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   pc_plus4;
    logic              deliver;

    assign target   = {PCTargetE[XLEN-1:2], 2'b00};
    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        wait_d      = wait_q;
        deliver     = 1'b0;
        imem_req    = 1'b0;
        InstrF      = NOP;
        PCF         = pc_q;

        case (state_q)
            BOOT: state_d = FETCH;

            FETCH: begin
                imem_req = 1'b1;
                if (PCSrcE) begin
                    pc_d = target;
                    if (imem_ack) addr_d  = target;
                    else          state_d = DROP;
                end else if (imem_ack && !HazStallD) begin
                    deliver = 1'b1;
                    InstrF  = imem_rdata;
                    PCF     = addr_q;
                    pc_d    = pc_plus4;
                    addr_d  = pc_plus4;
                end else if (imem_ack) begin
                    buf_instr_d = imem_rdata;
                    buf_pc_d    = addr_q;
                    state_d     = HOLD;
                end
            end

            HOLD: begin
                if (PCSrcE) begin
                    pc_d    = target;
                    addr_d  = target;
                    state_d = FETCH;
                end else if (!HazStallD) begin
                    deliver = 1'b1;
                    InstrF  = buf_instr_q;
                    PCF     = buf_pc_q;
                    pc_d    = pc_plus4;
                    addr_d  = pc_plus4;
                    state_d = FETCH;
                end
            end

            DROP: begin
                // Keep the abandoned request alive until memory completes it.
                imem_req = 1'b1;
                if (PCSrcE) pc_d = target;
                if (imem_ack) begin
                    addr_d  = pc_d;
                    state_d = FETCH;
                end
            end

            default: state_d = BOOT;
        endcase

        if (imem_req && !imem_ack && (wait_q != '1))
            wait_d = wait_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            buf_instr_q <= NOP;
            buf_pc_q    <= RESET_PC;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            wait_q      <= wait_d;
        end
    end

    assign imem_addr   = addr_q;
    assign StallF      = !deliver;
    assign StallD      = HazStallD;
    assign FlushD      = PCSrcE | HazFlushD | (!HazStallD & !deliver);
    assign wait_cycles = wait_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed and random steps checked against a
// transaction-level model of the fetch stream.
module tb_fetch_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        HazStallD = 1'b0;
    logic        HazFlushD = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic        StallF, StallD, FlushD;
    logic [15:0] wait_cycles;

    int compared = 0;
    int mismatched = 0;

    // Model: one request in flight (maybe no longer wanted), one held word.
    logic        m_boot;
    logic [31:0] m_pc;
    logic        m_req;
    logic        m_live;
    logic [31:0] m_req_addr;
    logic        m_held;
    logic [31:0] m_held_instr, m_held_pc;
    int          m_wait;

    fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .HazStallD(HazStallD), .HazFlushD(HazFlushD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .InstrF(InstrF), .PCF(PCF),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .wait_cycles(wait_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_pc = 32'h0; m_req = 1'b0; m_live = 1'b0;
        m_req_addr = 32'h0; m_held = 1'b0; m_held_instr = NOP; m_held_pc = 32'h0;
        m_wait = 0;
    endtask

    task automatic issue();
        m_req = 1'b1; m_live = 1'b1; m_req_addr = m_pc;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req",    32'(imem_req), 32'h0);
        chk("rst_instr",  InstrF, NOP);
        chk("rst_pcf",    PCF, 32'h0);
        chk("rst_stallf", 32'(StallF), 32'h1);
        chk("rst_stalld", 32'(StallD), 32'h0);
        chk("rst_flushd", 32'(FlushD), 32'h1);
        chk("rst_wait",   32'(wait_cycles), 32'h0);
    endtask

    // Called at a falling edge; drives inputs, checks, advances to next falling edge.
    task automatic step(input logic pcsrc, input logic [31:0] tgt, input logic hs,
                        input logic hf, input logic ack, input logic [31:0] rd,
                        input bit full_check);
        logic        dlv;
        logic [31:0] e_instr, e_pc, tgtm;
        PCSrcE = pcsrc; PCTargetE = tgt; HazStallD = hs; HazFlushD = hf;
        imem_ack = ack; imem_rdata = rd;
        #1;
        tgtm = tgt & 32'hFFFF_FFFC;
        dlv = 1'b0; e_instr = NOP; e_pc = m_pc;
        if (m_req && ack && m_live && !pcsrc && !hs) begin
            dlv = 1'b1; e_instr = rd; e_pc = m_req_addr;
        end else if (m_held && !pcsrc && !hs) begin
            dlv = 1'b1; e_instr = m_held_instr; e_pc = m_held_pc;
        end
        chk("req", 32'(imem_req), 32'(m_req));
        if (m_req) chk("addr", imem_addr, m_req_addr);
        chk("wait", 32'(wait_cycles), 32'(m_wait));
        if (full_check) begin
            chk("instrf", InstrF, e_instr);
            chk("pcf",    PCF, e_pc);
            chk("stallf", 32'(StallF), 32'(!dlv));
            chk("stalld", 32'(StallD), 32'(hs));
            chk("flushd", 32'(FlushD), 32'(pcsrc | hf | (!hs & !dlv)));
        end

        if (m_req && !ack && m_wait < 32'hFFFF) m_wait++;
        if (m_boot) begin
            m_boot = 1'b0; issue();
        end else if (m_held) begin
            if (pcsrc)    begin m_held = 1'b0; m_pc = tgtm; issue(); end
            else if (!hs) begin m_held = 1'b0; m_pc = m_pc + 32'd4; issue(); end
        end else if (m_req) begin
            if (ack) begin
                if (m_live) begin
                    if (pcsrc)    begin m_pc = tgtm; issue(); end
                    else if (!hs) begin m_pc = m_pc + 32'd4; issue(); end
                    else begin
                        m_req = 1'b0; m_held = 1'b1;
                        m_held_instr = rd; m_held_pc = m_req_addr;
                    end
                end else begin
                    if (pcsrc) m_pc = tgtm;
                    issue();
                end
            end else if (pcsrc) begin
                m_pc = tgtm; m_live = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #2 check_reset_outputs();
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // Zero-wait memory: BOOT then back-to-back fetches.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 32'h1000_0000 + i, 1);

        // Ack every third cycle.
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, (i % 3) == 2, 32'h2000_0000 + i, 1);

        // Decode stall across an ack, then release.
        step(0, 0, 1, 0, 1, 32'hCAFE_0001, 1);
        step(0, 0, 1, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 1, 32'h3000_0000, 1);

        // Redirect to 0x3E while a request is pending; stale ack dropped.
        step(0, 0, 0, 0, 0, 32'h0, 1);
        step(1, 32'h3E, 0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        step(0, 0, 0, 0, 1, 32'h4000_0000, 1);

        // Redirect while holding a buffered word.
        step(0, 0, 1, 0, 1, 32'h5000_0000, 1);
        step(1, 32'h40, 1, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 1, 32'h6000_0000, 1);

        // Randomized mix of waits, stalls, flushes and redirects.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 4) < 2, $urandom, 1);

        // Drain any held word so a request is outstanding, then starve it.
        for (int i = 0; i < 4 && !m_req; i++) step(0, 0, 0, 0, 0, 32'h0, 1);
        for (int i = 0; i < 70000; i++) step(0, 0, 0, 0, 0, 32'h0, (i % 1000) == 0);
        chk("wait_sat", 32'(wait_cycles), 32'h0000_FFFF);

        // Reset in the middle of an outstanding request.
        chk("req_before_rst", 32'(imem_req), 32'h1);
        #2 rst = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, i != 2, 32'h7000_0000 + i, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller that sequences the instruction-fetch stage against a variable-latency, single-outstanding instruction memory. It owns the fetch PC and the memory request/acknowledge handshake, and applies execute-stage redirects. It holds an instruction the decode stage cannot yet accept, and drives StallF/StallD/FlushD plus the fetched instruction and PC into the IF/ID register. It sits between the hazard unit, the IF/ID register and instruction memory.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, fetch PC after reset
CNT_W, 16, width of saturating wait-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
PCSrcE  in  1  execute-stage redirect (taken branch/jump)
PCTargetE  in  XLEN  redirect target
HazStallD  in  1  hazard unit: decode stage must hold
HazFlushD  in  1  hazard unit: decode stage must be bubbled
imem_req  out  1  instruction memory request
imem_addr  out  XLEN  request address, word aligned
imem_ack  in  1  request complete; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
InstrF  out  32  instruction into IF/ID
PCF  out  XLEN  PC of InstrF
StallF  out  1  fetch PC held this cycle
StallD  out  1  IF/ID hold
FlushD  out  1  IF/ID load bubble
wait_cycles  out  CNT_W  cycles a request was pending without ack

Behaviour:
- Reset (rst=0, async): state=BOOT, pc_q=addr_q=RESET_PC, buffer cleared, wait_cycles=0, imem_req=0, InstrF=32'h0000_0013 (NOP), PCF=RESET_PC, StallF=1, StallD=0, FlushD=1.
- Handshake: imem_req held high with imem_addr stable until the cycle imem_ack=1; a transfer completes on that edge. imem_ack is ignored when imem_req=0. At most one request is outstanding. A new request may issue the cycle after an ack.
- PCTargetE[1:0] forced to 0 on capture.
- deliver = an instruction enters IF/ID this edge. On deliver: pc_q<=pc_q+4 (wraps modulo 2^XLEN).
- Outputs: StallD=HazStallD. StallF=!deliver. FlushD=PCSrcE | HazFlushD | (!HazStallD & !deliver). InstrF/PCF are imem_rdata/addr_q when delivering from FETCH, the buffer contents when delivering from HOLD, and NOP/pc_q otherwise.
- States:
  BOOT: imem_req=0; next edge -> FETCH.
  FETCH: imem_req=1, imem_addr=addr_q(=pc_q).
    PCSrcE & ack: drop data; pc_q=addr_q=target; stay FETCH.
    PCSrcE & !ack: pc_q=target, addr_q unchanged; -> DROP.
    ack & !HazStallD: deliver; addr_q=pc_q+4; stay FETCH (back-to-back fetch).
    ack & HazStallD: buffer rdata/addr; -> HOLD.
    no ack: stay FETCH.
  HOLD: imem_req=0; buffered word valid.
    PCSrcE: discard buffer; addr_q=pc_q=target; -> FETCH.
    !HazStallD: deliver buffer; addr_q=pc_q+4; -> FETCH.
    else: stay HOLD.
  DROP: imem_req=1 with the old addr_q (the redirected-away request).
    On ack: data discarded; addr_q=pc_q; -> FETCH.
    Further PCSrcE in DROP: pc_q updated to the newest target.
- Priority: reset > PCSrcE > HazStallD > deliver. HazFlushD does not block deliver; the word it overwrites is the hazard unit's responsibility and is not refetched.
- wait_cycles: +1 every cycle imem_req=1 & !imem_ack (FETCH or DROP). Saturates at all-ones. Cleared only by reset.
- Reset mid-request: request abandoned; imem_req falls immediately (async). Memory must abort on rst.
- Throughput: 1 instr/cycle with zero-wait memory; latency from ack to IF/ID load = same edge.

Test Plan:
- Reset, ack tied 1: imem_req=0 for 1 cycle after rst rises; then addresses 0x0,0x4,0x8 on consecutive cycles; FlushD=1 only in the BOOT cycle; wait_cycles=0.
- ack every 3rd cycle: each instruction delivered on its ack edge; FlushD=1 and StallF=1 in the 2 wait cycles; wait_cycles=2 per instruction.
- HazStallD=1 for 2 cycles at ack of 0x8: go to HOLD, imem_req=0, StallD=1. On release, InstrF=buffered word, PCF=0x8, next request at 0xC.
- PCSrcE=1, PCTargetE=0x3E while request to 0x10 pending: enter DROP, old request held at 0x10. Its ack data is not delivered; next request at 0x3C; FlushD=1 throughout.
- PCSrcE in HOLD (target 0x40): buffer discarded, next request at 0x40, FlushD=1.
- Hold ack=0 for 70000 cycles: wait_cycles saturates at 16'hFFFF. Assert rst mid-request: imem_req drops asynchronously; all outputs return to reset values.
